// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan chain load/capture/unload controller with masked response compare
// Chain-facing outputs are registered so the clock-gate latch always sees a stable enable.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN      = 32,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_data,
  output logic                 chain_en,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CHAIN_LEN-1:0] response
);

  localparam int CNT_MAX = (CAPTURE_CYCLES > CHAIN_LEN) ? CAPTURE_CYCLES : CHAIN_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHIFT_CNT = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CAP_CNT   = CW'(CAPTURE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [CHAIN_LEN-1:0] pat_sr, pat_sr_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic [CHAIN_LEN-1:0] response_d;
  logic [CHAIN_LEN-1:0] shifted;
  logic                 scan_en_d, scan_data_d, chain_en_d, busy_d, done_d, fail_d;

  // First unloaded bit ends up in response[0] after CHAIN_LEN shifts.
  assign shifted = {scan_out, response[CHAIN_LEN-1:1]};

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state     <= IDLE;
      cnt       <= '0;
      pat_sr    <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      response  <= '0;
      scan_en   <= 1'b0;
      scan_data <= 1'b0;
      chain_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pat_sr    <= pat_sr_d;
      exp_q     <= exp_d;
      mask_q    <= mask_d;
      response  <= response_d;
      scan_en   <= scan_en_d;
      scan_data <= scan_data_d;
      chain_en  <= chain_en_d;
      busy      <= busy_d;
      done      <= done_d;
      fail      <= fail_d;
    end
  end

  // Every *_d value is what the registered output shows during the next state.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pat_sr_d    = pat_sr;
    exp_d       = exp_q;
    mask_d      = mask_q;
    response_d  = response;
    scan_en_d   = 1'b0;
    scan_data_d = 1'b0;
    chain_en_d  = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    fail_d      = fail;

    case (state)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          cnt_d       = SHIFT_CNT;
          pat_sr_d    = pattern >> 1;
          exp_d       = expected;
          mask_d      = mask;
          response_d  = '0;
          fail_d      = 1'b0;
          busy_d      = 1'b1;
          scan_en_d   = 1'b1;
          chain_en_d  = 1'b1;
          scan_data_d = pattern[0];
        end
      end
      LOAD: begin
        chain_en_d = 1'b1;
        if (cnt == CNT_ONE) begin
          state_d = CAPTURE;
          cnt_d   = CAP_CNT;
        end else begin
          cnt_d       = cnt - CNT_ONE;
          scan_en_d   = 1'b1;
          scan_data_d = pat_sr[0];
          pat_sr_d    = pat_sr >> 1;
        end
      end
      CAPTURE: begin
        chain_en_d = 1'b1;
        if (cnt == CNT_ONE) begin
          state_d   = UNLOAD;
          cnt_d     = SHIFT_CNT;
          scan_en_d = 1'b1;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      UNLOAD: begin
        response_d = shifted;
        if (cnt == CNT_ONE) begin
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fail_d  = |((shifted ^ exp_q) & mask_q);
        end else begin
          cnt_d      = cnt - CNT_ONE;
          scan_en_d  = 1'b1;
          chain_en_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      response_d  = '0;
      fail_d      = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      scan_en_d   = 1'b0;
      scan_data_d = 1'b0;
      chain_en_d  = 1'b0;
    end
  end

endmodule
